led_alert_driver: RTL and testbench
===================================

LED_ALERT_DRIVER -- requirements
Module: led_alert_driver

Interface
REQ-001 Parameter BLINK_TICKS, default 3: number of tick strobes per blink half-period, legal range 1..255.
REQ-002 Parameter PWM_BITS, default 4: width of the dimming PWM counter.
REQ-003 Parameter DIM_DUTY, default 4: PWM on-count per PWM period in SHOW state.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-clk-wide enable strobe from the divider stage; ignored when not exactly one cycle wide is not checked.
REQ-007 level  input  8  bar/shift pattern produced by the countdown counter stage.
REQ-008 critical  input  1  debounced threat flag (two-of-three fault condition).
REQ-009 leds  output  8  registered drive to the board LEDs.
REQ-010 state  output  2  current FSM state for debug: OFF=0, SHOW=1, ALERT=2, FULL=3.

Function
REQ-011 FSM shall have four states OFF, SHOW, ALERT, FULL, with next state evaluated every clk by fixed priority FULL > ALERT > SHOW > OFF.
REQ-012 Next state shall be FULL when level==8'hFF, else ALERT when critical==1, else SHOW when level!=0, else OFF.
REQ-013 leds and state shall be registered; a change on level or critical shall be visible on leds exactly one clk later.
REQ-014 OFF: leds shall be 8'h00.
REQ-015 SHOW: leds shall equal level while pwm_on==1, else 8'h00.
REQ-016 PWM counter shall be PWM_BITS wide, free-running, increment every clk, and wrap from all-ones to 0.
REQ-017 pwm_on shall be (pwm_cnt < DIM_DUTY); DIM_DUTY==0 gives permanently dark, DIM_DUTY >= 2**PWM_BITS gives permanently lit.
REQ-018 ALERT: leds shall equal level at full brightness while blink phase==1, else 8'h00.
REQ-019 Blink timer shall count tick strobes and toggle phase when the count reaches BLINK_TICKS-1 on a tick, then clear the count.
REQ-020 Entering ALERT from any other state shall set phase=1 and clear the tick count on the same edge.
REQ-021 FULL: leds shall be one-hot 8'b1 << pos; pos shall advance by 1 on each tick and wrap from 7 to 0.
REQ-022 Entering FULL from any other state shall set pos=0 on the same edge.
REQ-023 tick coinciding with a state entry shall be consumed by the entry and shall not advance pos or the tick count.
REQ-024 Leaving FULL or ALERT and re-entering shall always restart per REQ-020 and REQ-022, with no retained progress.
REQ-025 level changes inside SHOW or ALERT shall not reset the PWM counter or the blink timer.

Reset
REQ-026 Asserted reset (reset==0) shall immediately force state=OFF, leds=8'h00, pwm_cnt=0, tick count=0, phase=1, pos=0.
REQ-027 Reset asserted mid-blink or mid-chase shall discard all progress; after release, the first active edge shall evaluate REQ-012 normally.

Structure
REQ-028 State encoding constants and the one-hot chase base value shall live in shared package led_alert_pkg.
REQ-029 Tick counting and the phase toggle shall form one sub-module blink_timer, with inputs clk, reset, tick, and restart, and output phase.
REQ-030 The FSM, PWM counter, chase position, and output register shall stay in led_alert_driver.

Verification
REQ-031 reset pulse low for 3 clk with level=8'hFF -> leds=8'h00 and state=0 during reset; state=3 and leds=8'h01 on the 2nd clk after release.
REQ-032 level=8'h0F, critical=0, defaults -> leds=8'h0F for 4 of every 16 clk (pwm_cnt 0..3), else 8'h00.
REQ-033 critical=1, level=8'h3C, tick every 10 clk -> leds=8'h3C for 3 ticks, then 8'h00 for 3 ticks, repeating.
REQ-034 level=8'hFF, 9 ticks -> leds sequence 01,02,04,08,10,20,40,80,01,02.
REQ-035 critical=1 and level switches to 8'hFF on the same edge as a tick -> state=FULL, leds=8'h01, with the tick not counted.
REQ-036 reset asserted while in ALERT with phase=0 -> after release with critical still 1, leds=level immediately, i.e. phase restarts at 1.

Source files
------------

// File: rtl/led_alert_pkg.sv
// Shared definitions for the LED alert driver: state encoding, the chase
// base pattern and the next-state priority rule.
package led_alert_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALERT = 2'd2,
        ST_FULL  = 2'd3
    } led_state_e;

    // One-hot seed for the FULL-state chase; shifted left by the position.
    localparam logic [7:0] CHASE_BASE = 8'h01;

    // Level value that means "bar completely filled".
    localparam logic [7:0] LEVEL_FULL = 8'hFF;

    // Fixed priority FULL > ALERT > SHOW > OFF.
    function automatic led_state_e next_state(input logic [7:0] level,
                                              input logic       critical);
        led_state_e ns;
        if (level == LEVEL_FULL) begin
            ns = ST_FULL;
        end else if (critical) begin
            ns = ST_ALERT;
        end else if (level != 8'h00) begin
            ns = ST_SHOW;
        end else begin
            ns = ST_OFF;
        end
        return ns;
    endfunction

endpackage

// File: rtl/led_alert_if.sv
// Signal bundle between the counter/divider stages and the LED driver.
interface led_alert_if;

    logic       tick;
    logic [7:0] level;
    logic       critical;
    logic [7:0] leds;
    logic [1:0] state;

    // Upstream side: drives the strobe, pattern and threat flag.
    modport master (
        output tick,
        output level,
        output critical,
        input  leds,
        input  state
    );

    // LED driver side.
    modport slave (
        input  tick,
        input  level,
        input  critical,
        output leds,
        output state
    );

endinterface

// File: rtl/led_alert_driver_blink_timer.sv
// Blink timer: counts tick strobes and flips the blink phase every
// BLINK_TICKS ticks. restart holds the timer at the start of a lit phase.
module blink_timer #(
    parameter int unsigned BLINK_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic restart,
    output logic phase
);

    localparam logic [7:0] LAST_COUNT = 8'(BLINK_TICKS - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       phase_q;
    logic       phase_d;

    // Next count/phase: restart wins over tick, a tick at the last count toggles.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = 8'd0;
            phase_d = 1'b1;
        end else if (tick) begin
            if (cnt_q == LAST_COUNT) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Timer registers; reset lands at the start of a lit phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_alert_driver.sv
// LED alert driver: picks a display mode from the level/critical inputs
// and drives a registered LED pattern (dimmed bar, blinking bar, or chase).
module led_alert_driver
    import led_alert_pkg::*;
#(
    parameter int unsigned BLINK_TICKS = 3,
    parameter int unsigned PWM_BITS    = 4,
    parameter int unsigned DIM_DUTY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    led_alert_if.slave  bus
);

    localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

    led_state_e          state_q;
    led_state_e          state_d;
    logic [7:0]          leds_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [2:0]          pos_q;
    logic                pwm_on;
    logic                blink_restart;
    logic                blink_phase;
    logic                stay_full;

    // Mode selection from the current inputs.
    always_comb begin
        state_d = next_state(bus.level, bus.critical);
    end

    // Widen to 32 bits so DIM_DUTY beyond the counter range means "always lit".
    assign pwm_on = ({{(32 - PWM_BITS){1'b0}}, pwm_cnt_q} < DIM_DUTY);

    // The blink timer only runs while ALERT persists across an edge; any
    // entry (or time outside ALERT) pins it to a fresh lit phase, which also
    // makes an entry-cycle tick vanish.
    assign blink_restart = !((state_d == ST_ALERT) && (state_q == ST_ALERT));
    assign stay_full     = (state_d == ST_FULL) && (state_q == ST_FULL);

    blink_timer #(
        .BLINK_TICKS (BLINK_TICKS)
    ) u_blink_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (bus.tick),
        .restart (blink_restart),
        .phase   (blink_phase)
    );

    // FSM, free-running PWM counter, chase position and LED output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_OFF;
            leds_q    <= 8'h00;
            pwm_cnt_q <= '0;
            pos_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_ONE;

            // Position only moves on ticks inside an ongoing FULL stay;
            // everywhere else it sits at 0 so every entry starts the chase fresh.
            if (stay_full) begin
                if (bus.tick) begin
                    pos_q <= pos_q + 3'd1;
                end
            end else begin
                pos_q <= 3'd0;
            end

            case (state_d)
                ST_OFF:   leds_q <= 8'h00;
                ST_SHOW:  leds_q <= pwm_on ? bus.level : 8'h00;
                ST_ALERT: leds_q <= blink_phase ? bus.level : 8'h00;
                ST_FULL:  leds_q <= CHASE_BASE << pos_q;
                default:  leds_q <= 8'h00;
            endcase
        end
    end

    assign bus.leds  = leds_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_led_alert_driver.sv
// Testbench for led_alert_driver: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the display rules.
module tb_led_alert_driver;

    localparam int BLINK   = 3;
    localparam int PWMB    = 4;
    localparam int DIM     = 4;
    localparam int PWM_PER = 1 << PWMB;

    logic clk;
    logic reset;

    led_alert_if bus();

    led_alert_driver #(
        .BLINK_TICKS (BLINK),
        .PWM_BITS    (PWMB),
        .DIM_DUTY    (DIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt;
    int passed_cnt;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) begin
            passed_cnt++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Behavioural model: counts edges since reset (PWM phase) and ticks
    // seen while the current ALERT/FULL stay lasts.
    int         edge_n;
    int         alert_n;
    int         full_n;
    int         prev_st;
    int         ns_m;
    logic [7:0] exp_leds;
    logic [1:0] exp_state;

    always @(posedge clk) begin
        if (!reset) begin
            edge_n    = 0;
            alert_n   = 0;
            full_n    = 0;
            prev_st   = 0;
            exp_leds  = 8'h00;
            exp_state = 2'd0;
        end else begin
            if (bus.level == 8'hFF)      ns_m = 3;
            else if (bus.critical)       ns_m = 2;
            else if (bus.level != 8'h00) ns_m = 1;
            else                         ns_m = 0;
            case (ns_m)
                0: exp_leds = 8'h00;
                1: exp_leds = ((edge_n % PWM_PER) < DIM) ? bus.level : 8'h00;
                2: exp_leds = (((alert_n / BLINK) % 2) == 0) ? bus.level : 8'h00;
                default: exp_leds = 8'(1 << (full_n % 8));
            endcase
            if (ns_m == 2 && prev_st == 2) begin
                if (bus.tick) alert_n++;
            end else begin
                alert_n = 0;
            end
            if (ns_m == 3 && prev_st == 3) begin
                if (bus.tick) full_n++;
            end else begin
                full_n = 0;
            end
            edge_n++;
            prev_st   = ns_m;
            exp_state = 2'(ns_m);
        end
        #1;
        chk("model_leds", bus.leds, exp_leds);
        chk("model_state", {6'd0, bus.state}, {6'd0, exp_state});
    end

    logic [7:0] chase_seq [0:9];
    int         j;
    logic [7:0] lvl;
    logic       crit;
    int         len;

    initial begin
        total_cnt  = 0;
        passed_cnt = 0;
        chase_seq  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                       8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

        // Reset held for 3 clocks with a full bar.
        reset        = 1'b0;
        bus.level    = 8'hFF;
        bus.critical = 1'b0;
        bus.tick     = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_leds", bus.leds, 8'h00);
            chk("rst_state", {6'd0, bus.state}, 8'd0);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rel1_state", {6'd0, bus.state}, 8'd3);
        chk("rel1_leds", bus.leds, 8'h01);
        @(posedge clk); #1;
        chk("rel2_state", {6'd0, bus.state}, 8'd3);
        chk("rel2_leds", bus.leds, 8'h01);

        // Dimmed bar: lit on PWM counts 0..3 of every 16.
        @(negedge clk);
        reset     = 1'b0;
        bus.level = 8'h0F;
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            chk("show_pwm", bus.leds, ((i % 16) < 4) ? 8'h0F : 8'h00);
        end

        // Blinking bar with a tick every 10 clocks.
        @(negedge clk);
        bus.critical = 1'b1;
        bus.level    = 8'h3C;
        bus.tick     = 1'b0;
        @(posedge clk); #1;
        chk("alert_entry", bus.leds, 8'h3C);
        j = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk) bus.tick = ((k % 10) == 0);
            @(posedge clk); #1;
            chk("alert_blink", bus.leds, (((j / 3) % 2) == 0) ? 8'h3C : 8'h00);
            if (bus.tick) j++;
        end

        // Chase: 9 ticks walk the one-hot pattern and wrap.
        @(negedge clk);
        bus.tick  = 1'b0;
        bus.level = 8'hFF;
        @(posedge clk); #1;
        chk("chase_entry", bus.leds, chase_seq[0]);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
            @(posedge clk); #1;
            chk("chase_step", bus.leds, chase_seq[i]);
        end

        // FULL entry on the same edge as a tick: tick is swallowed.
        @(negedge clk);
        bus.level = 8'h3C;
        repeat (2) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
        end
        @(negedge clk);
        bus.level = 8'hFF;
        bus.tick  = 1'b1;
        @(posedge clk); #1;
        chk("entry_tick_state", {6'd0, bus.state}, 8'd3);
        chk("entry_tick_leds", bus.leds, 8'h01);
        @(negedge clk) bus.tick = 1'b0;
        @(posedge clk); #1;
        chk("entry_tick_hold", bus.leds, 8'h01);

        // Reset in the dark blink phase restarts lit.
        @(negedge clk) bus.level = 8'h3C;
        repeat (3) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
        end
        @(posedge clk); #1;
        chk("alert_dark", bus.leds, 8'h00);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("async_rst_leds", bus.leds, 8'h00);
        chk("async_rst_state", {6'd0, bus.state}, 8'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("alert_restart_leds", bus.leds, 8'h3C);
        chk("alert_restart_state", {6'd0, bus.state}, 8'd2);

        // Randomized segments, checked every cycle by the model.
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 4))
                0:       lvl = 8'h00;
                1:       lvl = 8'hFF;
                default: lvl = 8'($urandom_range(1, 254));
            endcase
            crit = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(20, 120));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (lvl != 8'h00 && lvl != 8'hFF && $urandom_range(0, 15) == 0)
                    lvl = 8'($urandom_range(1, 254));
                bus.level    = lvl;
                bus.critical = crit;
                bus.tick     = ($urandom_range(0, 3) == 0);
                reset        = ($urandom_range(0, 299) != 0);
            end
        end
        @(negedge clk);
        reset    = 1'b1;
        bus.tick = 1'b0;
        @(posedge clk); #2;

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
